abr_masked_mux_ctrl: RTL and testbench

Sequencer for the masked conditional-select datapath used in masked modular add/sub. It runs one job of NUM_COEFF coefficients through the non-stallable, fixed-latency masked MUX pipeline. Per coefficient it joins the coefficient stream with the randomness stream (rnd_xor/rnd_and from the PRNG) and gates issue on downstream buffer credits. It also tracks in-flight shares so that output valids align with the datapath result.

---
 rtl/abr_masked_mux_ctrl.sv | 128 ++++++++++++
 tb/tb_abr_masked_mux_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/abr_masked_mux_ctrl.sv
// Issue sequencer for the fixed-latency masked MUX datapath: joins the coefficient and
// randomness streams, gates issue on downstream credits and tracks in-flight shares.
module abr_masked_mux_ctrl #(
  parameter int WIDTH     = 23,
  parameter int LAT       = 2,
  parameter int NUM_COEFF = 256,
  parameter int CREDITS   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic zeroize,
  input  logic start_i,
  input  logic sub_i,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  logic rnd_valid_i,
  output logic rnd_ready_o,
  input  logic credit_ret_i,
  output logic issue_o,
  output logic mux_sub_o,
  output logic out_valid_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o
);

  localparam int CNT_W = $clog2(NUM_COEFF + 1);
  localparam int CR_W  = $clog2(CREDITS + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [LAT-1:0]   pipe_q, pipe_d;
  logic [CR_W-1:0]  credit_cnt_q, credit_cnt_d;
  logic             sub_q, sub_d;
  logic             err_q, err_d;
  logic             issue;

  // Both streams are consumed together so a coefficient never pairs with stale randomness.
  assign issue = (state_q == ST_RUN) && in_valid_i && rnd_valid_i && (credit_cnt_q != '0);

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    credit_cnt_d = credit_cnt_q;
    sub_d        = sub_q;
    err_d        = err_q;
    pipe_d       = LAT'({pipe_q, issue});

    if (issue) begin
      issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end

    if (issue && !credit_ret_i) begin
      credit_cnt_d = credit_cnt_q - CR_W'(1);
    end else if (credit_ret_i && !issue) begin
      if (credit_cnt_q == CR_W'(CREDITS)) begin
        err_d = 1'b1;
      end else begin
        credit_cnt_d = credit_cnt_q + CR_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d     = ST_RUN;
          sub_d       = sub_i;
          issue_cnt_d = '0;
        end
      end
      ST_RUN: begin
        if (issue && (issue_cnt_q == CNT_W'(NUM_COEFF - 1))) begin
          state_d = ST_DRAIN;
        end
      end
      // Leave DRAIN on the edge where the last in-flight share exits the pipe.
      ST_DRAIN: begin
        if (pipe_d == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (zeroize) begin
      state_d      = ST_IDLE;
      issue_cnt_d  = '0;
      pipe_d       = '0;
      credit_cnt_d = CR_W'(CREDITS);
      sub_d        = 1'b0;
      err_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      issue_cnt_q  <= '0;
      pipe_q       <= '0;
      credit_cnt_q <= CR_W'(CREDITS);
      sub_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      pipe_q       <= pipe_d;
      credit_cnt_q <= credit_cnt_d;
      sub_q        <= sub_d;
      err_q        <= err_d;
    end
  end

  assign in_ready_o  = issue;
  assign rnd_ready_o = issue;
  assign issue_o     = issue;
  assign mux_sub_o   = sub_q;
  assign out_valid_o = pipe_q[LAT-1];
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_abr_masked_mux_ctrl.sv
// Directed scenarios plus random traffic, checked every cycle against a job-level model
// built from issue times, a credit counter and a queue of pending output cycles.
module tb_abr_masked_mux_ctrl;

  localparam int WIDTH = 23;
  localparam int LAT   = 2;
  localparam int N     = 4;
  localparam int CR    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic zeroize = 1'b0;
  logic start_i = 1'b0;
  logic sub_i = 1'b0;
  logic in_valid_i = 1'b0;
  logic rnd_valid_i = 1'b0;
  logic credit_ret_i = 1'b0;
  logic in_ready_o, rnd_ready_o, issue_o, mux_sub_o, out_valid_o, busy_o, done_o, err_o;

  always #5 clk = ~clk;

  abr_masked_mux_ctrl #(
    .WIDTH(WIDTH), .LAT(LAT), .NUM_COEFF(N), .CREDITS(CR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .zeroize(zeroize), .start_i(start_i), .sub_i(sub_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .rnd_valid_i(rnd_valid_i), .rnd_ready_o(rnd_ready_o),
    .credit_ret_i(credit_ret_i), .issue_o(issue_o), .mux_sub_o(mux_sub_o),
    .out_valid_o(out_valid_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s1_base = -100;

  // model state
  bit m_busy, m_active, m_sub, m_sub_known, m_err;
  int m_issued, m_cred, m_done_cyc;
  int due_q[$];
  logic [9:0] pin_ir, pin_ov, pin_dn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_active = 0; m_sub = 0; m_sub_known = 1; m_err = 0;
    m_issued = 0; m_cred = CR; m_done_cyc = -1;
    due_q.delete();
  endtask

  // compare process: inputs are stable at the falling edge
  initial begin
    bit e_issue, e_ov, e_done, was_busy;
    model_clear();
    pin_ir = '0; pin_ov = '0; pin_dn = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        model_clear();
        chk("rst_issue", issue_o, 0);
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_rnd_ready", rnd_ready_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_mux_sub", mux_sub_o, 0);
        continue;
      end
      e_issue = m_active && in_valid_i && rnd_valid_i && (m_cred > 0);
      e_ov    = (due_q.size() > 0) && (due_q[0] == cyc);
      e_done  = m_busy && (m_done_cyc == cyc);
      chk("issue", issue_o, e_issue);
      chk("in_ready", in_ready_o, e_issue);
      chk("rnd_ready", rnd_ready_o, e_issue);
      chk("out_valid", out_valid_o, e_ov);
      chk("busy", busy_o, m_busy);
      chk("done", done_o, e_done);
      chk("err", err_o, m_err);
      if (m_sub_known) chk("mux_sub", mux_sub_o, m_sub);

      if (cyc >= s1_base && cyc < s1_base + 10) begin
        pin_ir[cyc - s1_base] = e_issue;
        pin_ov[cyc - s1_base] = e_ov;
        pin_dn[cyc - s1_base] = e_done;
      end
      if (cyc == s1_base + 10) begin
        chk("pin_in_ready_cycles", pin_ir, 10'h01E);
        chk("pin_out_valid_cycles", pin_ov, 10'h078);
        chk("pin_done_cycle", pin_dn, 10'h080);
      end

      if (e_ov) void'(due_q.pop_front());
      was_busy = m_busy;
      if (zeroize) begin
        model_clear();
      end else begin
        if (e_issue) begin
          due_q.push_back(cyc + LAT);
          m_issued++;
          if (m_issued == N) begin
            m_active = 0;
            m_done_cyc = cyc + LAT + 1;
          end
        end
        if (e_issue && !credit_ret_i) m_cred--;
        else if (credit_ret_i && !e_issue) begin
          if (m_cred == CR) m_err = 1;
          else m_cred++;
        end
        if (e_done) begin
          m_busy = 0;
          m_sub_known = 0;
        end
        if (!was_busy && start_i) begin
          m_busy = 1; m_active = 1; m_issued = 0; m_done_cyc = -1;
          m_sub = sub_i; m_sub_known = 1;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    step(2);

    // job with both streams valid and a credit returned on every issue
    in_valid_i = 1; rnd_valid_i = 1; sub_i = 0; start_i = 1; s1_base = cyc + 1;
    step(1);
    start_i = 0; credit_ret_i = 1;
    step(4);
    credit_ret_i = 0;
    step(7);

    // randomness withheld while coefficients wait
    start_i = 1; rnd_valid_i = 0;
    step(1);
    start_i = 0;
    step(3);
    rnd_valid_i = 1; credit_ret_i = 1;
    step(4);
    credit_ret_i = 0;
    step(8);

    // credit starvation, single return, then return coinciding with issue
    start_i = 1;
    step(1);
    start_i = 0;
    step(5);
    credit_ret_i = 1;
    step(1);
    credit_ret_i = 0;
    step(3);
    credit_ret_i = 1;
    step(2);
    credit_ret_i = 0;
    step(8);

    // zeroize one cycle after the second issue, start in the same cycle ignored
    credit_ret_i = 1; start_i = 1;
    step(1);
    start_i = 0;
    step(2);
    zeroize = 1; start_i = 1;
    step(1);
    zeroize = 0; start_i = 0; credit_ret_i = 0;
    step(5);
    start_i = 1;
    step(1);
    start_i = 0; credit_ret_i = 1;
    step(4);
    credit_ret_i = 0;
    step(8);

    // sub latched at start, toggled mid-job, extra start during RUN
    sub_i = 1; start_i = 1;
    step(1);
    start_i = 0;
    for (int i = 0; i < 10; i++) begin
      sub_i = ~sub_i;
      start_i = (i == 2);
      credit_ret_i = (i < 4);
      step(1);
    end
    start_i = 0; credit_ret_i = 0;
    step(3);

    // credit overflow sets a sticky error, cleared only by zeroize
    credit_ret_i = 1;
    step(1);
    credit_ret_i = 0;
    step(3);
    zeroize = 1;
    step(1);
    zeroize = 0;
    step(2);

    // asynchronous reset mid-job
    start_i = 1;
    step(1);
    start_i = 0;
    step(2);
    rst_n = 0;
    step(2);
    rst_n = 1;
    step(2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid_i   = ($urandom_range(0, 3) != 0);
      rnd_valid_i  = ($urandom_range(0, 3) != 0);
      credit_ret_i = ($urandom_range(0, 2) == 0);
      start_i      = ($urandom_range(0, 7) == 0);
      sub_i        = 1'($urandom_range(0, 1));
      zeroize      = ($urandom_range(0, 199) == 0);
      step(1);
    end
    in_valid_i = 0; rnd_valid_i = 0; credit_ret_i = 0; start_i = 0; zeroize = 0;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
